paddle_engine: RTL

PADDLE_ENGINE -- requirements
Module: paddle_engine

---
 rtl/paddle_engine_pkg.sv | 24 ++
 rtl/paddle_engine_if.sv | 34 +++
 rtl/key_fifo.sv | 67 ++++++
 rtl/paddle_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/paddle_engine_pkg.sv
// Shared definitions for the paddle engine: frame FSM state encoding,
// paddle position width and the default key codes (w/s for paddle 0,
// i/k for paddle 1).
package paddle_engine_pkg;

    localparam int POS_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        KEYS,
        CLEAR,
        DRAW,
        KICK
    } state_e;

    localparam logic [7:0] KEY_P0_UP   = 8'h77;
    localparam logic [7:0] KEY_P0_DOWN = 8'h73;
    localparam logic [7:0] KEY_P1_UP   = 8'h69;
    localparam logic [7:0] KEY_P1_DOWN = 8'h6B;

    localparam logic [15:0] DEFAULT_UP_KEYS   = {KEY_P1_UP, KEY_P0_UP};
    localparam logic [15:0] DEFAULT_DOWN_KEYS = {KEY_P1_DOWN, KEY_P0_DOWN};

endpackage

// File: rtl/paddle_engine_if.sv
// Host-side bundle of the paddle engine.
//   master: host / testbench (drives ENABLE, TICK, key strobe, GPU_READY)
//   slave : paddle_engine (drives key-FIFO status, framebuffer write port,
//           GPU_DRAW, BUSY and the packed paddle centre rows)
interface paddle_engine_if import paddle_engine_pkg::*; #(
    parameter int NUM_PADDLES = 2
) ();
    logic                           ENABLE;
    logic                           TICK;
    logic                           KEY_VALID;
    logic [7:0]                     KEY_CODE;
    logic                           KEY_FULL;
    logic                           OVERFLOW;
    logic                           MEM_ENABLE;
    logic                           MEM_WRITE;
    logic [15:0]                    MEM_ADDR;
    logic [15:0]                    MEM_DATA_W;
    logic                           GPU_READY;
    logic                           GPU_DRAW;
    logic                           BUSY;
    logic [POS_W*NUM_PADDLES-1:0]   PADDLE_POS;

    modport master (
        output ENABLE, TICK, KEY_VALID, KEY_CODE, GPU_READY,
        input  KEY_FULL, OVERFLOW, MEM_ENABLE, MEM_WRITE, MEM_ADDR,
               MEM_DATA_W, GPU_DRAW, BUSY, PADDLE_POS
    );

    modport slave (
        input  ENABLE, TICK, KEY_VALID, KEY_CODE, GPU_READY,
        output KEY_FULL, OVERFLOW, MEM_ENABLE, MEM_WRITE, MEM_ADDR,
               MEM_DATA_W, GPU_DRAW, BUSY, PADDLE_POS
    );
endinterface

// File: rtl/key_fifo.sv
// Key-code FIFO with first-word-fall-through output.
//   clk_i/rst_i : clock, asynchronous active-high reset
//   push_i/din_i: write strobe and 8-bit key code
//   pop_i       : consume head (ignored when empty)
//   dout_o      : current head entry
//   full_o/empty_o, overflow_o: status; overflow is sticky until reset
// A push while full is accepted only when a pop frees a slot in the same
// cycle; otherwise the key is dropped and overflow is raised.
module key_fifo import paddle_engine_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       overflow_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q;
    logic          do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign overflow_o = ovf_q;
    assign dout_o     = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !do_push) ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/paddle_engine.sv
// Paddle game frame engine. On each frame tick it drains queued key codes
// into paddle positions, optionally clears the framebuffer, draws every
// paddle as a vertical run of PIXEL words, then pulses GPU_DRAW.
//   CLK, RESET : clock, asynchronous active-high reset
//   io (slave) : ENABLE/TICK control, KEY_VALID/KEY_CODE key input with
//                KEY_FULL/OVERFLOW status, write-only framebuffer port
//                MEM_*, GPU_READY/GPU_DRAW handshake, BUSY, PADDLE_POS
module paddle_engine import paddle_engine_pkg::*; #(
    parameter int                           NUM_PADDLES = 2,
    parameter int                           FIELD_ROWS  = 18,
    parameter int                           PADDLE_LEN  = 4,
    parameter logic [15:0]                  FB_BASE     = 16'hA000,
    parameter logic [15:0]                  FB_WORDS    = 16'h0500,
    parameter int                           ROW_SHIFT   = 6,
    parameter logic [6*NUM_PADDLES-1:0]     PADDLE_COLS = {6'd61, 6'd2},
    parameter logic [8*NUM_PADDLES-1:0]     UP_KEYS     = DEFAULT_UP_KEYS,
    parameter logic [8*NUM_PADDLES-1:0]     DOWN_KEYS   = DEFAULT_DOWN_KEYS,
    parameter logic [15:0]                  PIXEL       = 16'h3F00,
    parameter int                           KEYQ_DEPTH  = 16,
    parameter bit                           CLEAR_EN    = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET,
    paddle_engine_if.slave  io
);
    localparam logic [POS_W-1:0] HALF     = POS_W'(PADDLE_LEN / 2);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(FIELD_ROWS - PADDLE_LEN / 2);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(FIELD_ROWS / 2);
    localparam logic [5:0]       LEN_LAST = 6'(PADDLE_LEN - 1);
    localparam logic [2:0]       P_LAST   = 3'(NUM_PADDLES - 1);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [15:0]      idx_q, idx_d;
    logic [2:0]       p_q, p_d;
    logic [5:0]       r_q, r_d;
    logic [POS_W-1:0] pos_q [NUM_PADDLES];
    logic [POS_W-1:0] pos_d [NUM_PADDLES];

    logic [7:0]       fifo_dout;
    logic             fifo_empty, fifo_full, fifo_ovf, fifo_pop;
    logic             matched;
    logic [POS_W-1:0] sel_pos;
    logic [5:0]       sel_col;
    logic [15:0]      row;
    logic             mem_en;
    logic [15:0]      mem_addr, mem_data;
    logic [POS_W*NUM_PADDLES-1:0] pos_flat;

    key_fifo #(.DEPTH(KEYQ_DEPTH)) u_key_fifo (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .push_i     (io.KEY_VALID),
        .din_i      (io.KEY_CODE),
        .pop_i      (fifo_pop),
        .dout_o     (fifo_dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    // Paddle currently being drawn.
    always_comb begin
        sel_pos = '0;
        sel_col = '0;
        for (int unsigned i = 0; i < NUM_PADDLES; i++) begin
            if (p_q == 3'(i)) begin
                sel_pos = pos_q[i];
                sel_col = PADDLE_COLS[i*6 +: 6];
            end
        end
    end

    assign row = 16'(sel_pos) - 16'(HALF) + 16'(r_q);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        p_d       = p_q;
        r_d       = r_q;
        pos_d     = pos_q;
        fifo_pop  = 1'b0;
        matched   = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;

        if (state_q != IDLE && io.TICK) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (io.TICK || pending_q) begin
                    state_d   = KEYS;
                    pending_d = 1'b0;
                end
            end
            KEYS: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Lowest-index paddle owning the code wins; up before down.
                    for (int unsigned p = 0; p < NUM_PADDLES; p++) begin
                        if (!matched && fifo_dout == UP_KEYS[p*8 +: 8]) begin
                            matched = 1'b1;
                            if (pos_q[p] > HALF) pos_d[p] = pos_q[p] - 1'b1;
                        end else if (!matched && fifo_dout == DOWN_KEYS[p*8 +: 8]) begin
                            matched = 1'b1;
                            if (pos_q[p] < POS_MAX) pos_d[p] = pos_q[p] + 1'b1;
                        end
                    end
                end else begin
                    idx_d = '0;
                    p_d   = '0;
                    r_d   = '0;
                    if (!io.GPU_READY) state_d = IDLE;
                    else if (CLEAR_EN) state_d = CLEAR;
                    else               state_d = DRAW;
                end
            end
            CLEAR: begin
                mem_en   = 1'b1;
                mem_addr = FB_BASE + idx_q;
                mem_data = '0;
                idx_d    = idx_q + 16'd1;
                if (idx_q == FB_WORDS - 16'd1) state_d = DRAW;
            end
            DRAW: begin
                mem_en   = 1'b1;
                mem_addr = FB_BASE + (row << ROW_SHIFT) + 16'(sel_col);
                mem_data = PIXEL;
                if (r_q == LEN_LAST) begin
                    r_d = '0;
                    if (p_q == P_LAST) state_d = KICK;
                    else               p_d = p_q + 3'd1;
                end else begin
                    r_d = r_q + 6'd1;
                end
            end
            KICK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything decided above; current-cycle outputs
        // still follow state_q so an in-flight write completes cleanly.
        if (!io.ENABLE) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            fifo_pop  = 1'b0;
            pos_d     = pos_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            idx_q     <= '0;
            p_q       <= '0;
            r_q       <= '0;
            for (int unsigned i = 0; i < NUM_PADDLES; i++) pos_q[i] <= POS_INIT;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            p_q       <= p_d;
            r_q       <= r_d;
            pos_q     <= pos_d;
        end
    end

    for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_pos
        assign pos_flat[g*POS_W +: POS_W] = pos_q[g];
    end

    assign io.KEY_FULL   = fifo_full;
    assign io.OVERFLOW   = fifo_ovf;
    assign io.MEM_ENABLE = mem_en;
    assign io.MEM_WRITE  = mem_en;
    assign io.MEM_ADDR   = mem_addr;
    assign io.MEM_DATA_W = mem_data;
    assign io.GPU_DRAW   = (state_q == KICK);
    assign io.BUSY       = (state_q != IDLE);
    assign io.PADDLE_POS = pos_flat;

endmodule
